// File: rtl/vi_stats_pkg.sv
// Shared types and default parameters for the stats interval controller.
package vi_stats_pkg;

  localparam int unsigned DEF_NUM_CH         = 4;
  localparam int unsigned DEF_INTERVAL_WIDTH = 32;
  localparam int unsigned DEF_WD_WIDTH       = 8;
  localparam int unsigned DEF_SEQ_WIDTH      = 16;
  localparam int unsigned DEF_OVR_WIDTH      = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LATCH = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } vi_state_e;

endpackage

// File: rtl/vi_interval_tick.sv
// Programmable period counter; tick_c pulses every cfg_interval cycles while enabled.
module vi_interval_tick
  import vi_stats_pkg::*;
#(
  parameter int unsigned INTERVAL_WIDTH = DEF_INTERVAL_WIDTH
) (
  input  logic                      clka,
  input  logic                      rsta_n,
  input  logic                      cfg_enable,
  input  logic [INTERVAL_WIDTH-1:0] cfg_interval,
  output logic                      tick_c
);

  logic [INTERVAL_WIDTH-1:0] cnt;
  logic                      armed;
  logic                      run_c;

  assign run_c  = cfg_enable && (cfg_interval != '0);
  assign tick_c = run_c && armed && (cnt == '0);

  // First load happens on the enable cycle; later loads on each tick pick up a new period.
  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      cnt   <= '0;
      armed <= 1'b0;
    end else if (!run_c) begin
      cnt   <= '0;
      armed <= 1'b0;
    end else if (!armed || (cnt == '0)) begin
      cnt   <= cfg_interval - INTERVAL_WIDTH'(1);
      armed <= 1'b1;
    end else begin
      cnt <= cnt - INTERVAL_WIDTH'(1);
    end
  end

endmodule

// File: rtl/vi_stats_interval_ctrl.sv
// Interval latch/clear scheduler: broadcasts latch pulses, gathers per-channel
// completion and publishes one stats-ready event per interval.
module vi_stats_interval_ctrl
  import vi_stats_pkg::*;
#(
  parameter int unsigned NUM_CH         = DEF_NUM_CH,
  parameter int unsigned INTERVAL_WIDTH = DEF_INTERVAL_WIDTH,
  parameter int unsigned WD_WIDTH       = DEF_WD_WIDTH,
  parameter int unsigned SEQ_WIDTH      = DEF_SEQ_WIDTH,
  parameter int unsigned OVR_WIDTH      = DEF_OVR_WIDTH
) (
  input  logic                      clka,
  input  logic                      rsta_n,
  input  logic                      cfg_enable,
  input  logic [INTERVAL_WIDTH-1:0] cfg_interval,
  input  logic                      sw_latch_req,
  input  logic [NUM_CH-1:0]         ch_clr_done_pulse,
  input  logic [NUM_CH-1:0]         ch_clr_timeout_level,
  output logic                      invl_latch_pulse,
  output logic                      busy,
  output logic                      stats_ready_pulse,
  output logic [NUM_CH-1:0]         timeout_mask,
  output logic                      wd_abort,
  output logic [SEQ_WIDTH-1:0]      invl_seq,
  output logic [OVR_WIDTH-1:0]      overrun_cnt
);

  // Last WAIT cycle before the watchdog counter would reach all ones.
  localparam logic [WD_WIDTH-1:0] WD_LAST = {{(WD_WIDTH-1){1'b1}}, 1'b0};

  vi_state_e           state_q, state_d;
  logic [NUM_CH-1:0]   pend_q, pend_d;
  logic [WD_WIDTH-1:0] wd_q, wd_d;
  logic                sw_pend_q;
  logic                abort_c;
  logic                tick_c;
  logic                trig_c;

  vi_interval_tick #(
    .INTERVAL_WIDTH(INTERVAL_WIDTH)
  ) u_tick (
    .clka        (clka),
    .rsta_n      (rsta_n),
    .cfg_enable  (cfg_enable),
    .cfg_interval(cfg_interval),
    .tick_c      (tick_c)
  );

  assign trig_c = tick_c || sw_latch_req || sw_pend_q;

  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      state_q <= ST_IDLE;
      pend_q  <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      wd_q    <= wd_d;
    end
  end

  // Next state; completion in the same cycle as the watchdog limit is not an abort.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    wd_d    = wd_q;
    abort_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (trig_c) state_d = ST_LATCH;
      end
      ST_LATCH: begin
        pend_d  = '1;
        wd_d    = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        pend_d = pend_q & ~ch_clr_done_pulse;
        wd_d   = wd_q + WD_WIDTH'(1);
        if (pend_d == '0) begin
          state_d = ST_DONE;
        end else if (wd_q == WD_LAST) begin
          state_d = ST_DONE;
          abort_c = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Registered outputs; interval results update together with stats_ready_pulse.
  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      invl_latch_pulse  <= 1'b0;
      busy              <= 1'b0;
      stats_ready_pulse <= 1'b0;
      timeout_mask      <= '0;
      wd_abort          <= 1'b0;
      invl_seq          <= '0;
      overrun_cnt       <= '0;
      sw_pend_q         <= 1'b0;
    end else begin
      invl_latch_pulse  <= (state_d == ST_LATCH);
      busy              <= (state_d != ST_IDLE);
      stats_ready_pulse <= (state_d == ST_DONE);
      if ((state_q == ST_WAIT) && (state_d == ST_DONE)) begin
        timeout_mask <= ch_clr_timeout_level | (abort_c ? pend_d : '0);
        wd_abort     <= abort_c;
        invl_seq     <= invl_seq + SEQ_WIDTH'(1);
      end
      if (state_d == ST_LATCH) begin
        sw_pend_q <= 1'b0;
      end else if ((state_q != ST_IDLE) && sw_latch_req) begin
        sw_pend_q <= 1'b1;
      end
      if ((state_q != ST_IDLE) && tick_c && (overrun_cnt != '1)) begin
        overrun_cnt <= overrun_cnt + OVR_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_vi_stats_interval_ctrl.sv
// Directed bench for vi_stats_interval_ctrl with a cycle-number transaction model.
module tb_vi_stats_interval_ctrl;

  localparam int NCH     = 4;
  localparam int IW      = 32;
  localparam int WDW     = 5;
  localparam int SQW     = 3;
  localparam int OVW     = 3;
  localparam int WD_SPAN = (1 << WDW) - 1;
  localparam int SEQ_MOD = 1 << SQW;
  localparam int OVR_MAX = (1 << OVW) - 1;

  logic           clka = 1'b0;
  logic           rsta_n = 1'b0;
  logic           cfg_enable = 1'b0;
  logic [IW-1:0]  cfg_interval = '0;
  logic           sw_latch_req = 1'b0;
  logic [NCH-1:0] done_p = '0;
  logic [NCH-1:0] to_lvl = '0;
  logic           invl_latch_pulse, busy, stats_ready_pulse, wd_abort;
  logic [NCH-1:0] timeout_mask;
  logic [SQW-1:0] invl_seq;
  logic [OVW-1:0] overrun_cnt;

  vi_stats_interval_ctrl #(
    .NUM_CH(NCH), .INTERVAL_WIDTH(IW), .WD_WIDTH(WDW), .SEQ_WIDTH(SQW), .OVR_WIDTH(OVW)
  ) dut (
    .clka                (clka),
    .rsta_n              (rsta_n),
    .cfg_enable          (cfg_enable),
    .cfg_interval        (cfg_interval),
    .sw_latch_req        (sw_latch_req),
    .ch_clr_done_pulse   (done_p),
    .ch_clr_timeout_level(to_lvl),
    .invl_latch_pulse    (invl_latch_pulse),
    .busy                (busy),
    .stats_ready_pulse   (stats_ready_pulse),
    .timeout_mask        (timeout_mask),
    .wd_abort            (wd_abort),
    .invl_seq            (invl_seq),
    .overrun_cnt         (overrun_cnt)
  );

  always #5 clka = ~clka;

  int cyc = 0;
  always @(posedge clka) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  function automatic void chk(string nm, longint act, longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Channel responders: done pulse resp_d cycles after each latch (-1 = never).
  int resp_d[NCH];
  bit resp_to[NCH];
  int sched[NCH];
  bit clr_lvl = 1'b0;

  initial for (int i = 0; i < NCH; i++) begin
    resp_d[i] = -1; resp_to[i] = 1'b0; sched[i] = -1;
  end

  always @(posedge clka) begin
    #1;
    if (clr_lvl || !rsta_n) begin
      to_lvl  = '0;
      clr_lvl = 1'b0;
    end
    for (int i = 0; i < NCH; i++) begin
      done_p[i] = rsta_n && (sched[i] == cyc);
      if (done_p[i] && resp_to[i]) to_lvl[i] = 1'b1;
    end
  end

  int lat_q[$];
  int rdy_q[$];
  int mask_q[$];
  int abrt_q[$];
  int seq_q[$];
  int ovr_q[$];

  // Model: transaction bookkeeping in absolute cycle numbers.
  bit             m_act = 1'b0;
  bit             m_swp = 1'b0;
  int             m_lat = -1, m_rdy = -1, m_nt = -1;
  logic [NCH-1:0] m_rem = '0;
  logic           e_latch = 1'b0, e_busy = 1'b0, e_ready = 1'b0, e_abort = 1'b0;
  logic [NCH-1:0] e_mask = '0;
  int             e_seq = 0, e_ovr = 0;

  always @(negedge clka) begin
    bit tick;
    if (!rsta_n) begin
      m_act = 1'b0; m_swp = 1'b0; m_lat = -1; m_rdy = -1; m_nt = -1; m_rem = '0;
      e_latch = 1'b0; e_busy = 1'b0; e_ready = 1'b0; e_abort = 1'b0;
      e_mask = '0; e_seq = 0; e_ovr = 0;
    end
    chk("latch_pulse", invl_latch_pulse, e_latch);
    chk("busy", busy, e_busy);
    chk("stats_ready", stats_ready_pulse, e_ready);
    chk("timeout_mask", timeout_mask, e_mask);
    chk("wd_abort", wd_abort, e_abort);
    chk("invl_seq", invl_seq, e_seq);
    chk("overrun_cnt", overrun_cnt, e_ovr);

    if (invl_latch_pulse) begin
      lat_q.push_back(cyc);
      clr_lvl = 1'b1;
      for (int i = 0; i < NCH; i++) sched[i] = (resp_d[i] < 0) ? -1 : cyc + resp_d[i];
    end
    if (stats_ready_pulse) begin
      rdy_q.push_back(cyc);
      mask_q.push_back(int'(timeout_mask));
      abrt_q.push_back(int'(wd_abort));
      seq_q.push_back(int'(invl_seq));
      ovr_q.push_back(int'(overrun_cnt));
    end

    if (rsta_n) begin
      tick = 1'b0;
      if (cfg_enable && cfg_interval != '0) begin
        if (m_nt < 0) m_nt = cyc + int'(cfg_interval);
        else if (cyc == m_nt) begin
          tick = 1'b1;
          m_nt = cyc + int'(cfg_interval);
        end
      end else begin
        m_nt = -1;
      end
      e_latch = 1'b0;
      e_ready = 1'b0;
      if (m_act) begin
        if (cyc == m_rdy) m_act = 1'b0;
        else if (cyc != m_lat && m_rdy < 0) begin
          m_rem = m_rem & ~done_p;
          if (m_rem == '0 || cyc - m_lat == WD_SPAN) begin
            m_rdy   = cyc + 1;
            e_ready = 1'b1;
            e_abort = (m_rem != '0);
            e_mask  = to_lvl | m_rem;
            e_seq   = (e_seq + 1) % SEQ_MOD;
          end
        end
        if (tick && e_ovr < OVR_MAX) e_ovr++;
        if (sw_latch_req) m_swp = 1'b1;
      end else if (tick || sw_latch_req || m_swp) begin
        m_act = 1'b1; m_lat = cyc + 1; m_rdy = -1; m_rem = '1; m_swp = 1'b0;
        e_latch = 1'b1;
      end
      e_busy = m_act;
    end
  end

  task automatic step(int n);
    repeat (n) @(posedge clka);
    #1;
  endtask

  task automatic set_resp(int d0, int d1, int d2, int d3, logic [3:0] to);
    resp_d[0] = d0; resp_d[1] = d1; resp_d[2] = d2; resp_d[3] = d3;
    for (int i = 0; i < NCH; i++) resp_to[i] = to[i];
  endtask

  task automatic clear_q();
    lat_q.delete(); rdy_q.delete(); mask_q.delete();
    abrt_q.delete(); seq_q.delete(); ovr_q.delete();
  endtask

  initial begin
    int k, s, r;
    step(2);
    chk("rst_busy", busy, 0);
    chk("rst_seq", invl_seq, 0);
    step(1);
    rsta_n = 1'b1;
    step(3);

    // Periodic operation, interval 100
    clear_q();
    set_resp(5, 9, 12, 20, 4'b0000);
    cfg_interval = 100; cfg_enable = 1'b1; k = cyc;
    step(330);
    chk("t1_nlat", lat_q.size(), 3);
    chk("t1_nrdy", rdy_q.size(), 3);
    if (lat_q.size() == 3 && rdy_q.size() == 3) begin
      chk("t1_first_lat", lat_q[0] - k, 101);
      chk("t1_spacing0", lat_q[1] - lat_q[0], 100);
      chk("t1_spacing1", lat_q[2] - lat_q[1], 100);
      for (int i = 0; i < 3; i++) begin
        chk("t1_lat2rdy", rdy_q[i] - lat_q[i], 21);
        chk("t1_mask", mask_q[i], 0);
        chk("t1_seq", seq_q[i], i + 1);
      end
    end
    cfg_enable = 1'b0;
    step(5);

    // Channel 2 timeout reported with its done pulse
    clear_q();
    set_resp(3, 4, 6, 5, 4'b0100);
    sw_latch_req = 1'b1; s = cyc;
    step(1);
    sw_latch_req = 1'b0;
    step(15);
    chk("t2_nrdy", rdy_q.size(), 1);
    if (rdy_q.size() == 1) begin
      chk("t2_lat", rdy_q[0] - s, 8);
      chk("t2_mask", mask_q[0], 4);
      chk("t2_abort", abrt_q[0], 0);
      chk("t2_seq", seq_q[0], 4);
    end

    // Watchdog abort with channel 3 silent
    clear_q();
    set_resp(2, 3, 4, -1, 4'b0000);
    sw_latch_req = 1'b1;
    step(1);
    sw_latch_req = 1'b0;
    step(40);
    chk("t3_nrdy", rdy_q.size(), 1);
    if (rdy_q.size() == 1 && lat_q.size() == 1) begin
      chk("t3_lat2rdy", rdy_q[0] - lat_q[0], 32);
      chk("t3_abort", abrt_q[0], 1);
      chk("t3_mask", mask_q[0], 8);
    end

    // Software request while busy is deferred, not counted as overrun
    clear_q();
    set_resp(2, 2, 2, 2, 4'b0000);
    sw_latch_req = 1'b1; s = cyc;
    step(1);
    sw_latch_req = 1'b0;
    step(1);
    sw_latch_req = 1'b1;
    step(1);
    sw_latch_req = 1'b0;
    step(15);
    chk("t5_nlat", lat_q.size(), 2);
    if (lat_q.size() == 2 && rdy_q.size() == 2) begin
      chk("t5_first_lat", lat_q[0] - s, 1);
      chk("t5_after_done", lat_q[1] - rdy_q[0], 2);
      chk("t5_abort_clr", abrt_q[0], 0);
      chk("t5_seq", seq_q[1], 7);
    end
    chk("t5_ovr", overrun_cnt, 0);

    // Software request coinciding with a tick merges into one latch
    clear_q();
    cfg_interval = 50; cfg_enable = 1'b1; k = cyc;
    step(50);
    sw_latch_req = 1'b1;
    step(1);
    sw_latch_req = 1'b0;
    step(20);
    cfg_enable = 1'b0;
    step(5);
    chk("t5b_nlat", lat_q.size(), 1);
    if (lat_q.size() == 1) chk("t5b_lat", lat_q[0] - k, 51);
    chk("t5b_ovr", overrun_cnt, 0);
    chk("t5b_seq_wrap", invl_seq, 0);

    // Overrun: ticks every 10 cycles, intervals take 27
    clear_q();
    set_resp(10, 15, 20, 25, 4'b0000);
    cfg_interval = 10; cfg_enable = 1'b1; k = cyc;
    step(135);
    cfg_enable = 1'b0;
    step(30);
    chk("t4_nlat", lat_q.size(), 5);
    chk("t4_nrdy", rdy_q.size(), 5);
    if (lat_q.size() == 5 && rdy_q.size() == 5) begin
      chk("t4_first_lat", lat_q[0] - k, 11);
      for (int i = 1; i < 5; i++) chk("t4_spacing", lat_q[i] - lat_q[i-1], 30);
      chk("t4_ovr0", ovr_q[0], 2);
      chk("t4_ovr1", ovr_q[1], 4);
      chk("t4_ovr2", ovr_q[2], 6);
      chk("t4_ovr_sat", ovr_q[3], 7);
      chk("t4_ovr_hold", ovr_q[4], 7);
    end
    chk("t4_ovr_end", overrun_cnt, 7);

    // Reset in the middle of WAIT
    clear_q();
    set_resp(5, -1, -1, -1, 4'b0000);
    cfg_interval = 40; cfg_enable = 1'b1; k = cyc;
    step(46);
    chk("t6_in_wait", busy, 1);
    rsta_n = 1'b0;
    #1;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_seq", invl_seq, 0);
    chk("t6_rst_ovr", overrun_cnt, 0);
    step(3);
    chk("t6_no_ready", rdy_q.size(), 0);
    clear_q();
    set_resp(3, 3, 3, 3, 4'b0000);
    rsta_n = 1'b1; r = cyc;
    step(60);
    cfg_enable = 1'b0;
    chk("t6_nlat", lat_q.size(), 1);
    if (lat_q.size() >= 1) chk("t6_first_lat", lat_q[0] - r, 41);
    chk("t6_seq", invl_seq, 1);
    step(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
